// File: rtl/tjrpu_wb_master.sv
// tjrpu_wb_master: single-outstanding Wishbone classic-cycle master with valid/ready
// command and response ports and a bounded bus timeout.
module tjrpu_wb_master #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [3:0]    cmd_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i
);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [1:0] state_q, state_d;
  logic [TW-1:0] timer_q;
  logic tmo;
  always_comb begin
    tmo = (TIMEOUT != 0) && timer_q == T_LAST;
    state_d = state_q == IDLE ? (cmd_valid ? BUS : IDLE)
            : state_q == BUS ? (wbm_err_i || wbm_ack_i || tmo ? RESP : BUS)
            : state_q == RESP && !rsp_ready ? RESP : IDLE;
  end
  assign cmd_ready = state_q == IDLE;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we;
        wbm_adr_o <= cmd_addr & ~AW'(3);
        wbm_dat_o <= cmd_wdata;
        wbm_sel_o <= cmd_sel;
        timer_q   <= '0;
      end
      // err beats ack; with neither present the termination is a timeout
      if (state_q == BUS) begin
        if (state_d == RESP) begin
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_err     <= wbm_err_i || !wbm_ack_i;
          rsp_timeout <= !wbm_err_i && !wbm_ack_i;
          rsp_rdata   <= wbm_ack_i && !wbm_err_i && !wbm_we_o ? wbm_dat_i : '0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_valid   <= 1'b0;
        rsp_err     <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tjrpu_wb_master.sv
// tb_tjrpu_wb_master: table-driven, randomized and hand-sequenced checks of the Wishbone master.
module tb_tjrpu_wb_master;
  localparam int TMO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0, rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, rsp_rdata, wbm_adr_o, wbm_dat_o, wbm_dat_i = 0;
  logic [3:0] cmd_sel = 0, wbm_sel_o;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 0, wbm_err_i = 0;
  int n_vec = 0, n_bad = 0;

  tjrpu_wb_master #(.AW(32), .DW(32), .TIMEOUT(TMO), .TW(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  // kind: 0 ack, 1 err, 2 err+ack together, 3 silent slave
  typedef struct {
    logic we; logic [31:0] a, d; logic [3:0] s; int waits, kind; logic [31:0] sd;
    logic [31:0] e_adr, e_rdata; logic e_err, e_to; int e_cyc, hold;
  } vec_t;
  vec_t tbl[6];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int k;
    logic ok;
    logic [31:0] r_d;
    logic r_e, r_t;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    cmd_valid = 1; cmd_we = v.we; cmd_addr = v.a; cmd_wdata = v.d; cmd_sel = v.s;
    step;
    cmd_valid = 0; cmd_we = ~v.we; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_sel = 4'($urandom);
    k = 0;
    ok = 1;
    while (wbm_cyc_o && k < 300) begin
      if (k == 0) begin
        chk("adr_o", wbm_adr_o, v.e_adr);
        chk("dat_o", wbm_dat_o, v.d);
        chk("sel_o", {28'd0, wbm_sel_o}, {28'd0, v.s});
        chk("we_o", {31'd0, wbm_we_o}, {31'd0, v.we});
      end
      if (wbm_adr_o !== v.e_adr || wbm_dat_o !== v.d || wbm_sel_o !== v.s || wbm_we_o !== v.we ||
          wbm_stb_o !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) ok = 0;
      wbm_ack_i = k == v.waits && v.kind != 3 && v.kind != 1;
      wbm_err_i = k == v.waits && (v.kind == 1 || v.kind == 2);
      wbm_dat_i = k == v.waits ? v.sd : $urandom;
      step;
      wbm_ack_i = 0; wbm_err_i = 0;
      k++;
    end
    chk("bus_stable", {31'd0, ok}, 1);
    chk("cyc_cycles", k, v.e_cyc);
    chk("stb_low", {31'd0, wbm_stb_o}, 0);
    chk("rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.e_err});
    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.e_to});
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    r_d = rsp_rdata; r_e = rsp_err; r_t = rsp_timeout;
    ok = 1;
    for (int j = 0; j < v.hold; j++) begin
      wbm_ack_i = j == 1;
      wbm_err_i = j == 2;
      step;
      wbm_ack_i = 0; wbm_err_i = 0;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r_d || rsp_err !== r_e || rsp_timeout !== r_t ||
          cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) ok = 0;
    end
    if (v.hold > 0) chk("rsp_hold", {31'd0, ok}, 1);
    rsp_ready = 1;
    step;
    rsp_ready = 0;
    chk("rsp_drop", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 1);
  endtask

  initial begin
    int hs, nb, nr, rdy;
    vec_t v;
    tbl[0] = '{1'b1, 32'h3000_0006, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'hAAAA_AAAA,
               32'h3000_0004, 32'h0, 1'b0, 1'b0, 1, 0};
    tbl[1] = '{1'b0, 32'h1000_0000, 32'h0BAD_F00D, 4'hF, 3, 0, 32'h1234_5678,
               32'h1000_0000, 32'h1234_5678, 1'b0, 1'b0, 4, 5};
    tbl[2] = '{1'b0, 32'h2000_0008, 32'h0, 4'hF, 2, 2, 32'h5555_5555,
               32'h2000_0008, 32'h0, 1'b1, 1'b0, 3, 1};
    tbl[3] = '{1'b0, 32'h4000_0013, 32'h0, 4'h1, 0, 3, 32'h7777_7777,
               32'h4000_0010, 32'h0, 1'b1, 1'b1, 4, 4};
    tbl[4] = '{1'b1, 32'h5000_000F, 32'hCAFE_0001, 4'h3, 1, 1, 32'h9999_9999,
               32'h5000_000C, 32'h0, 1'b1, 1'b0, 2, 0};
    tbl[5] = '{1'b0, 32'h6000_0020, 32'h0, 4'hC, 4, 0, 32'h1111_2222,
               32'h6000_0020, 32'h0, 1'b1, 1'b1, 4, 2};

    step; step;
    rst = 0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_outs", {26'd0, rsp_valid, rsp_err, rsp_timeout, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_sel", {28'd0, wbm_sel_o}, 0);

    wbm_ack_i = 1; wbm_err_i = 1;
    step;
    wbm_ack_i = 0; wbm_err_i = 0;
    chk("idle_spurious", {30'd0, wbm_cyc_o, rsp_valid}, 0);

    foreach (tbl[i]) run_txn(tbl[i]);

    // randomized transactions against a transaction-level model
    for (int i = 0; i < 25; i++) begin
      logic to_hit;
      v.we = 1'($urandom); v.a = $urandom; v.d = $urandom; v.s = 4'($urandom);
      v.waits = $urandom_range(0, 6); v.kind = $urandom_range(0, 3); v.sd = $urandom;
      v.hold = $urandom_range(0, 3);
      to_hit = v.kind == 3 || v.waits >= TMO;
      v.e_cyc = to_hit ? TMO : v.waits + 1;
      v.e_err = to_hit || v.kind != 0;
      v.e_to = to_hit;
      v.e_rdata = (v.e_err || v.we) ? 32'h0 : v.sd;
      v.e_adr = {v.a[31:2], 2'b00};
      run_txn(v);
    end

    // back-to-back reads with rsp_ready and cmd_valid held high
    hs = 0; nb = 0; nr = 0; rdy = 0;
    rsp_ready = 1; cmd_valid = 1; cmd_we = 0; cmd_addr = 0; cmd_sel = 4'hF;
    for (int i = 0; i < 9; i++) begin
      logic took;
      took = cmd_ready && cmd_valid;
      if (cmd_ready) rdy++;
      wbm_ack_i = wbm_cyc_o;
      wbm_dat_i = wbm_adr_o + 32'h100;
      step;
      if (took) begin
        hs++;
        cmd_addr = cmd_addr + 4;
        if (hs == 3) cmd_valid = 0;
      end
      if (wbm_cyc_o) begin
        chk("b2b_adr", wbm_adr_o, 32'(4 * nb));
        nb++;
      end
      if (rsp_valid) begin
        chk("b2b_rdata", rsp_rdata, 32'(4 * nr + 32'h100));
        nr++;
      end
    end
    wbm_ack_i = 0; rsp_ready = 0;
    chk("b2b_handshakes", hs, 3);
    chk("b2b_ready_cycles", rdy, 3);
    chk("b2b_bus_cycles", nb, 3);
    chk("b2b_responses", nr, 3);

    // reset during a wait state
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h7000_0000;
    step;
    cmd_valid = 0;
    step;
    chk("pre_rst_cyc", {31'd0, wbm_cyc_o}, 1);
    rst = 1;
    step;
    rst = 0;
    chk("rst_bus_outs", {29'd0, wbm_cyc_o, wbm_stb_o, rsp_valid}, 0);
    step;
    chk("rst_bus_ready", {31'd0, cmd_ready}, 1);
    chk("rst_bus_quiet", {30'd0, wbm_cyc_o, rsp_valid}, 0);
    v = '{1'b0, 32'h7000_0104, 32'h0, 4'hF, 1, 0, 32'hFEED_0042,
          32'h7000_0104, 32'hFEED_0042, 1'b0, 1'b0, 2, 1};
    run_txn(v);

    // reset while a response is pending
    v.hold = 0;
    cmd_valid = 1; cmd_addr = 32'h0;
    step;
    cmd_valid = 0; wbm_ack_i = 1;
    step;
    wbm_ack_i = 0;
    chk("pre_rst_rsp", {31'd0, rsp_valid}, 1);
    rst = 1;
    step;
    rst = 0;
    chk("rst_resp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_resp_ready", {31'd0, cmd_ready}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tjrpu_wb_master.md
Name: tjrpu_wb_master

Overview:
- Wishbone classic-cycle bus master (initiator) inside the tjrpu user project.
- Complements the existing Wishbone slave port that serves the management SoC: lets the tjrpu core issue single reads and writes to Wishbone peripherals.
- Accepts one command at a time over a valid/ready interface.
- Runs exactly one Wishbone cycle per command with a bounded timeout.
- Returns data and status over a valid/ready response interface.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be 32.
- TIMEOUT, 255, max BUS cycles before forced error termination; 0 disables the timeout.
- TW, 8, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address.
- cmd_wdata  in  DW  write data.
- cmd_sel  in  4  byte-lane select.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DW  read data; 0 for writes and for errors.
- rsp_err  out  1  bus error or timeout.
- rsp_timeout  out  1  error was caused by timeout.
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle/strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select.
- wbm_adr_o  out  AW  address, bits [1:0] forced to 0.
- wbm_dat_o  out  DW  write data.
- wbm_dat_i  in  DW  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error termination.

Behaviour:
- All outputs are registered, except cmd_ready, which is decoded from state.
- Reset values: state IDLE; cmd_ready 1 (from the following cycle); rsp_valid 0; rsp_rdata 0; rsp_err 0; rsp_timeout 0; wbm_cyc_o 0; wbm_stb_o 0; wbm_we_o 0; wbm_sel_o 0; wbm_adr_o 0; wbm_dat_o 0; timer 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at an edge: latch we, addr (with [1:0] zeroed), wdata and sel onto the wbm_* outputs.
  - Set cyc = stb = 1, clear the timer, go to BUS.
  - All of this is visible the cycle after the handshake.
- BUS:
  - cmd_ready = 0; cyc/stb held high; address, data, sel and we held stable.
  - Each edge samples ack/err:
    - err_i = 1 (wins over ack_i if both are high): rsp_err = 1, rsp_rdata = 0.
    - else ack_i = 1: rsp_err = 0; rsp_rdata = wbm_dat_i for a read, 0 for a write.
    - else, if TIMEOUT != 0 and timer == TIMEOUT-1: rsp_err = 1, rsp_timeout = 1.
    - else: timer += 1, stay in BUS.
  - On any of the three terminations: cyc = stb = 0 at that edge, rsp_valid = 1, go to RESP.
- RESP:
  - cmd_ready = 0; rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid = 0, rsp_err = 0, rsp_timeout = 0, go to IDLE.
  - The next command can be accepted in the cycle after the rsp handshake; there is no combinational rsp_ready-to-cmd_ready path.
- Latency:
  - With the command accepted at edge 0 and a zero-wait slave (ack_i high in the first stb cycle), ack is sampled at edge 1 and rsp_valid is high after edge 1.
  - Each slave wait state adds 1 cycle.
  - cyc is high for exactly 1 + waits cycles.
- ack_i/err_i while in IDLE or RESP are ignored: no state change and no rsp update (covers late or spurious acks after a timeout).
- Reset mid-BUS: cyc/stb low after the reset edge, any pending response discarded, state IDLE.
- Reset mid-RESP: rsp_valid low after the reset edge.
- cmd_* inputs are don't-care outside the IDLE handshake; changes during BUS do not affect the wbm_* outputs.

Test Plan:
- Zero-wait write: cmd {we=1, addr=0x3000_0006, wdata=0xDEAD_BEEF, sel=0xF}; slave acks in the first stb cycle -> adr_o = 0x3000_0004, dat_o = 0xDEAD_BEEF, cyc high for 1 cycle; rsp_valid high the next cycle with err = 0, rdata = 0.
- Read with 3 wait states: slave returns 0x1234_5678 -> cyc high for exactly 4 cycles; rsp_rdata = 0x1234_5678, err = 0; hold rsp_ready low 5 cycles -> rsp fields stable and cmd_ready stays 0.
- Error termination: slave asserts err_i and ack_i together on wait cycle 2 -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- Timeout, TIMEOUT=4, slave silent -> cyc high for exactly 4 cycles, then rsp_err = 1, rsp_timeout = 1; an ack_i pulse 2 cycles later -> no change to any output.
- Back-to-back: rsp_ready and cmd_valid held high, 3 reads to 0x0, 0x4, 0x8 with a zero-wait slave -> each command completes, cmd_ready is high exactly once per transaction, and the address sequence is correct.
- Reset mid-BUS: assert wb_rst_i 1 cycle during a wait state -> cyc/stb = 0 and rsp_valid = 0 after the edge; cmd_ready = 1 the following cycle; a subsequent read completes normally.
